sram_ctrl: RTL

Parametrised asynchronous-SRAM controller that replaces the fixed 16-bit, two-phase SRAM bridge on the FPGA boards. It sits between the core's `mem_in_type`/`mem_out_type` memory port and an external async SRAM of 8- or 16-bit width. Relative to the old bridge it adds:
- separate read and write wait counts;
- write-lane skipping by strobe;
- a bus-turnaround recovery phase;
- a one-entry pending-request buffer;
- out-of-range error reporting.

---
 rtl/sram_ctrl_pkg.sv | 40 ++++
 rtl/sram_pending.sv | 53 +++++
 rtl/sram_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and limits for the async-SRAM controller family.
// The request/response records, FSM state codes and elaboration limits live here so later controllers can reuse them.
package sram_ctrl_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        mem_error;
    } mem_out_type;

    typedef logic [2:0] sram_state_type;

    localparam sram_state_type S_IDLE    = 3'd0;
    localparam sram_state_type S_SETUP   = 3'd1;
    localparam sram_state_type S_WSTROBE = 3'd2;
    localparam sram_state_type S_WHOLD   = 3'd3;
    localparam sram_state_type S_READ    = 3'd4;
    localparam sram_state_type S_RESP    = 3'd5;
    localparam sram_state_type S_RECOVER = 3'd6;

    localparam int SRAM_WIDTH_NARROW = 8;
    localparam int SRAM_WIDTH_WIDE   = 16;
    localparam int SRAM_MAX_WAIT     = 256;

    // One bit per SRAM lane: set when any byte strobe of that lane is set.
    function automatic logic [3:0] lane_mask(input logic [3:0] wstrb, input int lanes);
        if (lanes == 4) begin
            return wstrb;
        end
        return {2'b00, |wstrb[3:2], |wstrb[1:0]};
    endfunction

endpackage

// File: rtl/sram_pending.sv
// One-entry request buffer that holds a request arriving while the controller is busy.
module sram_pending
    import sram_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  mem_in_type req_i,
    output mem_in_type req_o,
    output logic       full_o
);

    logic        full_q, full_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // A push while already full is dropped; the requester protocol never does that.
    always_comb begin
        full_d  = full_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i && req_i.mem_valid && !full_q) begin
            full_d  = 1'b1;
            addr_d  = req_i.mem_addr;
            wdata_d = req_i.mem_wdata;
            wstrb_d = req_i.mem_wstrb;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            full_q  <= full_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign full_o = full_q;
    assign req_o  = '{mem_valid: full_q, mem_addr: addr_q, mem_wdata: wdata_q, mem_wstrb: wstrb_q};

endmodule

// File: rtl/sram_ctrl.sv
// Async-SRAM controller: splits a 32-bit memory-port access into 8- or 16-bit SRAM lane cycles.
// Every SRAM strobe and response bit comes straight from a flop, computed from the next state.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int sram_width = 16,
    parameter int addr_width = 18,
    parameter int read_wait  = 2,
    parameter int write_wait = 2,
    parameter int turnaround = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  mem_in_type              sram_in,
    output mem_out_type             sram_out,
    output logic                    sram_ce_n,
    output logic                    sram_we_n,
    output logic                    sram_oe_n,
    output logic [sram_width/8-1:0] sram_be_n,
    inout  wire  [sram_width-1:0]   sram_dq,
    output logic [addr_width-1:0]   sram_addr
);

    localparam int LANES     = 32 / sram_width;
    localparam int LANE_BITS = (LANES == 4) ? 2 : 1;
    localparam int BE_W      = sram_width / 8;
    localparam int ERR_BIT   = addr_width + ((sram_width == 16) ? 1 : 0);

    localparam logic [7:0] RW_LAST = 8'(read_wait - 1);
    localparam logic [7:0] WW_LAST = 8'(write_wait - 1);
    localparam logic [7:0] TA_LAST = 8'(turnaround - 1);

    if (sram_width != SRAM_WIDTH_NARROW && sram_width != SRAM_WIDTH_WIDE) begin : g_width_check
        $error("sram_ctrl: sram_width must be 8 or 16");
    end
    if (read_wait < 1 || read_wait > SRAM_MAX_WAIT || write_wait < 1 || write_wait > SRAM_MAX_WAIT
        || turnaround < 1 || turnaround > SRAM_MAX_WAIT) begin : g_wait_check
        $error("sram_ctrl: wait and turnaround counts must be within 1..256");
    end

    typedef struct packed {
        sram_state_type        state;
        logic [1:0]            lane;
        logic [7:0]            cnt;
        logic [31:0]           addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic                  err;
        logic [31:0]           rbuf;
        logic                  ce_n;
        logic                  we_n;
        logic                  oe_n;
        logic [BE_W-1:0]       be_n;
        logic                  dq_oe;
        logic [sram_width-1:0] dq_out;
        logic [addr_width-1:0] sram_addr;
        logic                  ready;
        logic                  error;
        logic [31:0]           rdata;
    } reg_type;

    reg_type    r_q, r_d;
    mem_in_type pend_req, req;
    logic       pend_full, pend_push, pend_pop;
    logic [3:0] req_mask, cur_mask;
    logic [1:0] first_lane, next_lane;
    logic       has_next;

    sram_pending u_pending (
        .clock  (clock),
        .reset  (reset),
        .push_i (pend_push),
        .pop_i  (pend_pop),
        .req_i  (sram_in),
        .req_o  (pend_req),
        .full_o (pend_full)
    );

    assign req      = pend_full ? pend_req : sram_in;
    assign req_mask = lane_mask(req.mem_wstrb, LANES);
    assign cur_mask = lane_mask(r_q.wstrb, LANES);

    // Descending scan so the lowest qualifying lane is the one left standing.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        has_next   = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (req_mask[k]) begin
                first_lane = 2'(k);
            end
            if (cur_mask[k] && (2'(k) > r_q.lane)) begin
                next_lane = 2'(k);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        reg_type v;
        logic    take;
        v         = r_q;
        take      = 1'b0;
        pend_pop  = 1'b0;

        case (r_q.state)
            S_IDLE: take = 1'b1;
            S_SETUP: begin
                v.state = S_WSTROBE;
                v.cnt   = '0;
            end
            S_WSTROBE: begin
                if (r_q.cnt == WW_LAST) begin
                    v.state = S_WHOLD;
                end else begin
                    v.cnt = r_q.cnt + 8'd1;
                end
            end
            S_WHOLD: begin
                if (has_next) begin
                    v.lane  = next_lane;
                    v.state = S_SETUP;
                end else begin
                    v.state = S_RESP;
                end
            end
            S_READ: begin
                if (r_q.cnt == RW_LAST) begin
                    v.rbuf[r_q.lane*sram_width +: sram_width] = sram_dq;
                    v.cnt = '0;
                    if (r_q.lane == 2'(LANES - 1)) begin
                        v.state = S_RESP;
                        v.rdata = v.rbuf;
                    end else begin
                        v.lane = r_q.lane + 2'd1;
                    end
                end else begin
                    v.cnt = r_q.cnt + 8'd1;
                end
            end
            S_RESP: begin
                v.state = S_RECOVER;
                v.cnt   = '0;
            end
            S_RECOVER: begin
                if (r_q.cnt == TA_LAST) begin
                    take = 1'b1;
                end else begin
                    v.cnt = r_q.cnt + 8'd1;
                end
            end
            default: v.state = S_IDLE;
        endcase

        // The final recovery cycle doubles as the acceptance point so a pending request loses no cycle.
        if (take) begin
            v.state = S_IDLE;
            v.cnt   = '0;
            v.lane  = '0;
            if (req.mem_valid) begin
                pend_pop = pend_full;
                v.addr   = req.mem_addr;
                v.wdata  = req.mem_wdata;
                v.wstrb  = req.mem_wstrb;
                v.err    = |(req.mem_addr >> ERR_BIT);
                if (v.err) begin
                    v.state = S_RESP;
                end else if (|req.mem_wstrb) begin
                    v.state = S_SETUP;
                    v.lane  = first_lane;
                end else begin
                    v.state = S_READ;
                end
            end
        end
        pend_push = sram_in.mem_valid && !pend_full && !take;

        v.ready     = (v.state == S_RESP);
        v.error     = (v.state == S_RESP) && v.err;
        v.dq_oe     = (v.state == S_SETUP) || (v.state == S_WSTROBE) || (v.state == S_WHOLD);
        v.ce_n      = !(v.dq_oe || (v.state == S_READ));
        v.we_n      = (v.state != S_WSTROBE);
        v.oe_n      = (v.state != S_READ);
        v.dq_out    = v.wdata[v.lane*sram_width +: sram_width];
        v.sram_addr = {v.addr[addr_width+1-LANE_BITS:2], v.lane[LANE_BITS-1:0]};
        if (v.state == S_READ) begin
            v.be_n = '0;
        end else if (v.dq_oe) begin
            v.be_n = ~v.wstrb[v.lane*BE_W +: BE_W];
        end else begin
            v.be_n = '1;
        end

        r_d = v;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q       <= '0;
            r_q.state <= S_IDLE;
            r_q.ce_n  <= 1'b1;
            r_q.we_n  <= 1'b1;
            r_q.oe_n  <= 1'b1;
            r_q.be_n  <= '1;
        end else begin
            r_q <= r_d;
        end
    end

    assign sram_out  = '{mem_ready: r_q.ready, mem_rdata: r_q.rdata, mem_error: r_q.error};
    assign sram_ce_n = r_q.ce_n;
    assign sram_we_n = r_q.we_n;
    assign sram_oe_n = r_q.oe_n;
    assign sram_be_n = r_q.be_n;
    assign sram_addr = r_q.sram_addr;
    assign sram_dq   = r_q.dq_oe ? r_q.dq_out : {sram_width{1'bz}};

endmodule
